// File: rtl/tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_frame_arbiter
// Purpose  : Shares one 48-bit UART frame transmitter between NUM_REQ
//            requesters. The default build uses round-robin arbitration.
//            Defining TX_ARB_FIXED_PRIO_EN selects fixed priority instead
//            (lowest index wins, pointer held at 0).
// Revision : 1.0 - initial release
// ============================================================================
module tx_frame_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [48*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    input  logic                   pause,
    output logic [2:0]             grant_id,
    output logic                   active,
    output logic [47:0]            tx_data,
    output logic                   tx_new_data,
    input  logic                   tx_busy
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_LAUNCH     = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 active_q, active_d;
    logic                 txnew_q, txnew_d;
    logic [2:0]           gid_q, gid_d;
    logic [2:0]           ptr_q, ptr_d;
    logic [47:0]          txd_q, txd_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [7:0]           w_req_ext;
    logic [3:0]           w_idx;
    logic                 w_found;
    logic [2:0]           w_win;
    logic [47:0]          w_win_data;
    logic [2:0]           w_ptr_next;

    assign w_req_ext = 8'(req);

`ifdef TX_ARB_FIXED_PRIO_EN
    assign w_ptr_next = 3'd0;
`else
    assign w_ptr_next = (gid_q == 3'(NUM_REQ - 1)) ? 3'd0 : gid_q + 3'd1;
`endif

    // Search starts at the pointer and wraps at NUM_REQ-1 back to 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_idx   = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, ptr_q} + 4'(k);
            if (w_idx >= 4'(NUM_REQ))
                w_idx = w_idx - 4'(NUM_REQ);
            if (!w_found && w_req_ext[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[2:0];
            end
        end
    end

    always_comb begin
        w_win_data = 48'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == 3'(i))
                w_win_data = req_data[48*i +: 48];
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        txnew_d  = 1'b0;
        active_d = active_q;
        gid_d    = gid_q;
        txd_d    = txd_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        case (state_q)
            S_IDLE: begin
                // The cycle showing done is skipped so a new launch trails done by two cycles.
                if (!pause && w_found && (done_q == '0)) begin
                    for (int i = 0; i < NUM_REQ; i++)
                        ack_d[i] = (w_win == 3'(i));
                    txnew_d  = 1'b1;
                    active_d = 1'b1;
                    gid_d    = w_win;
                    txd_d    = w_win_data;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(START_TIMEOUT)) begin
                        err_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    for (int i = 0; i < NUM_REQ; i++)
                        done_d[i] = (gid_q == 3'(i));
                    active_d = 1'b0;
                    ptr_d    = w_ptr_next;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
            txnew_q  <= 1'b0;
            gid_q    <= 3'd0;
            txd_q    <= 48'd0;
            cnt_q    <= 8'd0;
            ptr_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            active_q <= active_d;
            txnew_q  <= txnew_d;
            gid_q    <= gid_d;
            txd_q    <= txd_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign err         = err_q;
    assign active      = active_q;
    assign tx_new_data = txnew_q;
    assign grant_id    = gid_q;
    assign tx_data     = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_frame_arbiter
// Purpose  : Self-checking bench for tx_frame_arbiter: vector table, directed
//            corner sequences and randomized traffic against a grant model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_frame_arbiter;

    localparam int N = 4;
    localparam int T = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [48*N-1:0]  req_data = '0;
    logic [N-1:0]     ack, done;
    logic             err;
    logic             pause = 1'b0;
    logic [2:0]       grant_id;
    logic             active;
    logic [47:0]      tx_data;
    logic             tx_new_data;
    logic             tx_busy;

    int  errors = 0;
    int  checks = 0;
    bit  tx_en  = 1'b1;
    int  tx_len = 3;
    int  tx_cnt;

    tx_frame_arbiter #(.NUM_REQ(N), .START_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .ack(ack), .done(done), .err(err), .pause(pause),
        .grant_id(grant_id), .active(active), .tx_data(tx_data),
        .tx_new_data(tx_new_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    // Transmitter with a registered busy flag lasting tx_len cycles.
    always @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx_cnt  <= 0;
        end else if (tx_new_data && tx_en) begin
            tx_busy <= 1'b1;
            tx_cnt  <= tx_len;
        end else if (tx_cnt > 1) begin
            tx_cnt  <= tx_cnt - 1;
        end else begin
            tx_busy <= 1'b0;
            tx_cnt  <= 0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; pause = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference pick: first requesting index at or after the pointer, cyclically.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic wait_done(output logic [N-1:0] d, output int launches);
        d = '0;
        launches = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (tx_new_data) launches++;
            if (done != '0) begin
                d = done;
                return;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         pause;
        logic [N-1:0] ack;
        logic [2:0]   gid;
        logic         act;
    } vec_t;

    vec_t         tbl[7];
    logic [N-1:0] d;
    int           nl, k, acks3, dones, launches, w;
    int           order[5];
    int           exp_order[5];
    logic [63:0]  r64;

    initial begin
        tbl[0] = '{req: 4'b0010, pause: 1'b0, ack: 4'b0010, gid: 3'd1, act: 1'b1};
        tbl[1] = '{req: 4'b1100, pause: 1'b0, ack: 4'b0100, gid: 3'd2, act: 1'b1};
        tbl[2] = '{req: 4'b1000, pause: 1'b0, ack: 4'b1000, gid: 3'd3, act: 1'b1};
        tbl[3] = '{req: 4'b1111, pause: 1'b1, ack: 4'b0000, gid: 3'd0, act: 1'b0};
        tbl[4] = '{req: 4'b0000, pause: 1'b0, ack: 4'b0000, gid: 3'd0, act: 1'b0};
        tbl[5] = '{req: 4'b1111, pause: 1'b0, ack: 4'b0001, gid: 3'd0, act: 1'b1};
        tbl[6] = '{req: 4'b1010, pause: 1'b0, ack: 4'b0010, gid: 3'd1, act: 1'b1};

        // Reset state
        do_reset();
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_active", active, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_txnew", tx_new_data, 0);

        // Vector table: one IDLE decision from a freshly reset arbiter
        for (int i = 0; i < 7; i++) begin
            do_reset();
            for (int j = 0; j < N; j++) begin
                r64 = {$urandom(), $urandom()};
                req_data[48*j +: 48] = r64[47:0];
            end
            req = tbl[i].req;
            pause = tbl[i].pause;
            tick();
            chk("tbl_ack", ack, tbl[i].ack);
            chk("tbl_gid", grant_id, tbl[i].gid);
            chk("tbl_active", active, tbl[i].act);
            chk("tbl_txnew", tx_new_data, tbl[i].act);
            chk("tbl_txdata", tx_data, tbl[i].act ? req_data[48*tbl[i].gid +: 48] : 48'd0);
        end

        // Single request with a known frame
        do_reset();
        tx_len = 4;
        req_data[95:48] = 48'hA1B2C3D4E5F6;
        req = 4'b0010;
        tick();
        chk("single_ack", ack, 4'b0010);
        chk("single_txnew", tx_new_data, 1);
        chk("single_txdata", tx_data, 48'hA1B2C3D4E5F6);
        req = '0;
        wait_done(d, nl);
        chk("single_done", d, 4'b0010);
        chk("single_extra_launch", nl, 0);
        chk("single_active", active, 0);
        chk("single_gid", grant_id, 1);

        // Continuous requests from all four
        do_reset();
        tx_len = 2;
        req = 4'b1111;
        k = 0;
        for (int c = 0; c < 300 && k < 5; c++) begin
            tick();
            if (ack != '0) begin
                order[k] = int'(grant_id);
                k++;
            end
        end
`ifdef TX_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        chk("cont_count", k, 5);
        for (int i = 0; i < 5; i++)
            chk("cont_order", (i < k) ? order[i] : -1, exp_order[i]);
        req = '0;
        wait_done(d, nl);

        // Launch timeout
        do_reset();
        tx_en = 1'b0;
        req = 4'b0100;
        tick();
        chk("to_txnew", tx_new_data, 1);
        req = '0;
        dones = 0;
        k = 0;
        for (int c = 1; c <= T + 20; c++) begin
            tick();
            if (done != '0) dones++;
            if (err) begin
                k = c;
                break;
            end
        end
        chk("to_err_cycle", k, T + 1);
        chk("to_active", active, 0);
        chk("to_no_done", dones, 0);
        tick();
        chk("to_err_pulse", err, 0);
        tx_en = 1'b1;
        req = 4'b1010;
        tick();
        chk("to_ptr_kept", grant_id, 1);
        req = '0;
        wait_done(d, nl);
        chk("to_recover_done", d, 4'b0010);

        // Pause before and during a frame
        do_reset();
        pause = 1'b1;
        req = 4'b1111;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack != '0) k++;
        end
        chk("pause_no_ack", k, 0);
        pause = 1'b0;
        tick();
        chk("pause_grant", ack, 4'b0001);
        w = int'(grant_id);
        req[w] = 1'b0;
        pause = 1'b1;
        wait_done(d, nl);
        chk("pause_done", d, oh(w));
        k = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ack != '0) k++;
        end
        chk("pause_hold", k, 0);
        pause = 1'b0;
        tick();
        chk("pause_release", |ack, 1);
        req = '0;
        wait_done(d, nl);

        // Reset during WAIT_DONE
        do_reset();
        tx_len = 10;
        req = 4'b0001;
        tick();
        req = '0;
        for (int c = 0; c < 10 && !tx_busy; c++) tick();
        chk("rstmid_busy", tx_busy, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_active", active, 0);
        chk("rstmid_txnew", tx_new_data, 0);
        chk("rstmid_gid", grant_id, 0);
        chk("rstmid_done", done, 0);
        rst = 1'b0;
        req = 4'b0100;
        tick();
        chk("rstmid_regrant", ack, 4'b0100);
        chk("rstmid_regrant_gid", grant_id, 2);
        req = '0;
        wait_done(d, nl);

        // Withdrawn request while another frame is active
        do_reset();
        tx_len = 4;
        req = 4'b0001;
        tick();
        req = '0;
        tick();
        req = 4'b1000;
        tick();
        req = '0;
        acks3 = 0; dones = 0; launches = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ack[3]) acks3++;
            if (tx_new_data) launches++;
            if (done != '0) dones++;
        end
        chk("wd_no_ack3", acks3, 0);
        chk("wd_no_launch", launches, 0);
        chk("wd_one_done", dones, 1);

        // Randomized traffic against the grant model
        begin
            logic [47:0]  fr[N];
            logic [N-1:0] prev_req;
            logic         prev_pause;
            bit           inflight;
            int           cur, mptr, starve, exp_w;
            do_reset();
            inflight = 1'b0; cur = 0; mptr = 0; starve = 0;
            for (int c = 0; c < 4000; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && ($urandom_range(0, 3) == 0)) begin
                        r64 = {$urandom(), $urandom()};
                        fr[i] = r64[47:0];
                        req_data[48*i +: 48] = fr[i];
                        req[i] = 1'b1;
                    end
                end
                if ($urandom_range(0, 15) == 0) pause = ~pause;
                tx_len = $urandom_range(1, 4);
                prev_req = req;
                prev_pause = pause;
                tick();
                if (ack == '0 && !inflight && prev_req != '0 && !prev_pause)
                    starve++;
                else
                    starve = 0;
                if (starve > 3) begin
                    chk("rnd_starve", starve, 3);
                    starve = 0;
                end
                if (err) chk("rnd_err", err, 0);
                if (done != '0) begin
                    chk("rnd_done_inflight", inflight, 1);
                    chk("rnd_done_id", done, oh(cur));
`ifndef TX_ARB_FIXED_PRIO_EN
                    mptr = (cur + 1) % N;
`endif
                    inflight = 1'b0;
                end
                if (ack != '0) begin
                    exp_w = pick(prev_req, mptr);
                    chk("rnd_ack", ack, (exp_w < 0) ? '0 : oh(exp_w));
                    chk("rnd_ack_idle", inflight, 0);
                    chk("rnd_ack_pause", prev_pause, 0);
                    chk("rnd_txnew", tx_new_data, 1);
                    if (exp_w >= 0) begin
                        chk("rnd_txdata", tx_data, fr[exp_w]);
                        cur = exp_w;
                    end
                    inflight = 1'b1;
                    req = req & ~ack;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Shares one 6-byte (48-bit) UART frame transmitter between up to eight requesters. Requesters post a 48-bit frame with a request/acknowledge handshake; the arbiter picks one, hands its frame to the transmitter with a single-cycle launch strobe, and tracks the transmitter's busy flag until the frame has left the line. It sits between the packet producers (sensor/ADC formatters) and the serial transmitter.

## Interface
- NUM_REQ, 4: number of requesters, legal 2..8.
- START_TIMEOUT, 15: cycles allowed between launch and tx_busy rising, legal 2..255.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  per-requester frame request; held until ack.
- req_data  in  48*NUM_REQ  frame of requester i at bits [48*i+47:48*i]; byte 0 = bits [7:0], sent first.
- ack  out  NUM_REQ  one-cycle pulse: frame of requester i captured.
- done  out  NUM_REQ  one-cycle pulse: frame of requester i fully transmitted.
- err  out  1  one-cycle pulse: launch timed out.
- pause  in  1  when high, no new grant is issued; a frame in flight completes.
- grant_id  out  3  index of current/last granted requester.
- active  out  1  high from capture until done/err.
- tx_data  out  48  frame to transmitter, registered, stable while active.
- tx_new_data  out  1  one-cycle launch strobe to transmitter.
- tx_busy  in  1  transmitter busy flag.

## Operation
- States: IDLE, LAUNCH, WAIT_START, WAIT_DONE.
- IDLE: if pause=0 and req≠0, select winner (see arbitration), register tx_data=req_data[winner], grant_id=winner, pulse ack[winner] next cycle, active=1, go LAUNCH. Otherwise stay.
- LAUNCH: tx_new_data=1 for exactly this state's one cycle; clear timeout counter; go WAIT_START.
- WAIT_START: if tx_busy=1 go WAIT_DONE. Else increment counter; on reaching START_TIMEOUT pulse err, active=0, go IDLE (no done, pointer not advanced, requester must re-request).
- WAIT_DONE: when tx_busy=0 pulse done[grant_id], active=0, advance pointer to grant_id+1 mod NUM_REQ, go IDLE.
- Arbitration (default): round-robin; search starts at pointer, wraps at NUM_REQ-1→0; reset pointer 0.
- req deasserted before ack: request withdrawn, no effect. req_data must be stable while req=1; captured value is the one present in the IDLE decision cycle.
- Simultaneous requests: exactly one ack per grant; losers keep req high and are served in pointer order.
- pause rising during a frame: frame completes normally; no further grant until pause=0.
- Illegal state encodings return to IDLE.

## Timing
- Reset values: ack=0, done=0, err=0, grant_id=0, active=0, tx_data=0, tx_new_data=0, state IDLE, pointer 0, counter 0.
- req seen in IDLE at cycle N: ack, active, tx_data valid at N+1; tx_new_data high at N+1 only.
- With a transmitter whose busy is registered, tx_busy rises at N+2; WAIT_DONE entered N+3.
- done pulses the cycle after tx_busy is sampled low; next IDLE decision the following cycle, so minimum gap from done to next tx_new_data is 2 cycles.
- Every output registered; no combinational path from req or tx_busy to any output.
- rst mid-frame: all outputs to reset values next cycle; pending requesters must re-request; transmitter assumed reset by the same rst.

## Configuration
- TX_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; pointer logic removed, pointer held 0.
- Not defined: round-robin as described.

## Test plan
- Single request: req=0b0010, req_data[95:48]=48'hA1B2C3D4E5F6 -> ack[1] at N+1, one tx_new_data pulse, tx_data=48'hA1B2C3D4E5F6, done[1] after busy falls, grant_id=1.
- All four request continuously -> grant order 0,1,2,3,0 (round-robin); with TX_ARB_FIXED_PRIO_EN order 0,0,0… while req[0] held.
- tx_busy held 0 after launch -> err pulse exactly START_TIMEOUT cycles after entering WAIT_START, no done, active=0, pointer unchanged.
- pause=1 while req=0b1111 -> no ack; pause asserted during frame -> frame finishes with done, no new ack until pause=0.
- rst asserted in WAIT_DONE -> next cycle active=0, tx_new_data=0, grant_id=0; after release, req=0b0100 -> granted requester 2.
- req[3] pulsed one cycle while frame for requester 0 active -> request withdrawn, no ack[3], no extra frame.
